tx_ethernet: RTL



---
 rtl/tx_ethernet.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/tx_ethernet.sv
// Ethernet II frame transmitter, GMII transmit side.
// Sends preamble, SFD, header, streamed payload, zero pad and FCS, then holds off for the
// inter-frame gap. Every output is a flop; next-state and next-output logic is one process.
module tx_ethernet #(
  parameter int unsigned OCT         = 8,
  parameter logic [7:0]  PRE         = 8'b10101010,
  parameter logic [7:0]  SFD         = 8'b10101011,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned IFG         = 12
) (
  input  logic           TX_CLK,
  input  logic           rst,
  input  logic [47:0]    mac_addr,
  input  logic [47:0]    tx_mac_dst,
  input  logic [15:0]    tx_ethertype,
  input  logic           tx_start,
  input  logic [OCT-1:0] tx_payload,
  input  logic           tx_payload_v,
  input  logic           tx_payload_last,
  output logic           tx_payload_rdy,
  output logic           tx_busy,
  output logic           tx_done,
  output logic           tx_err,
  output logic           TX_EN,
  output logic           TX_ER,
  output logic [OCT-1:0] TXD
);

  localparam logic [10:0] MinLen  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MaxLen  = 11'(MAX_PAYLOAD);
  localparam logic [3:0]  GapLast = 4'(IFG - 1);

  // The state names the beat currently on TXD (StAbort is the single TX_ER beat).
  typedef enum logic [3:0] {
    StIdle, StPre, StSfd, StDst, StSrc, StType, StPay, StPad, StFcs, StAbort, StGap
  } state_e;

  state_e        st_q, st_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [10:0]   byte_cnt_q, byte_cnt_d;  // payload + pad bytes placed on the wire
  logic [111:0]  hdr_q, hdr_d;            // {dst, src, type}, shifted out MSB byte first
  logic [31:0]   crc_q, crc_d;
  logic          over_q, over_d;
  logic          rdy_d, busy_d, done_d, err_d, en_d, er_d;
  logic [OCT-1:0] txd_d;

  // Reflected CRC-32, one byte LSB-first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Next state, then the outputs of the beat that next state will put on the wire.
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q + 4'd1;
    byte_cnt_d = byte_cnt_q;
    hdr_d      = hdr_q;
    crc_d      = crc_q;
    over_d     = over_q;
    rdy_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    en_d       = 1'b0;
    er_d       = 1'b0;
    txd_d      = '0;

    unique case (st_q)
      StIdle: begin
        cnt_d = '0;
        if (tx_start) begin
          st_d       = StPre;
          hdr_d      = {tx_mac_dst, mac_addr, tx_ethertype};
          crc_d      = '1;
          byte_cnt_d = '0;
          over_d     = 1'b0;
        end
      end
      StPre: begin
        if (cnt_q == 4'd6) begin
          st_d  = StSfd;
          cnt_d = '0;
        end
      end
      StSfd: begin
        st_d  = StDst;
        cnt_d = '0;
      end
      StDst: begin
        if (cnt_q == 4'd5) begin
          st_d  = StSrc;
          cnt_d = '0;
        end
      end
      StSrc: begin
        if (cnt_q == 4'd5) begin
          st_d  = StType;
          cnt_d = '0;
        end
      end
      StType, StPay: begin
        if (st_q == StType && cnt_q == 4'd0) begin
          // Ready goes up one beat early so byte 0 follows the EtherType directly.
          rdy_d = 1'b1;
        end else if (tx_payload_rdy) begin
          if (tx_payload_v) begin
            st_d       = StPay;
            byte_cnt_d = byte_cnt_q + 11'd1;
            if (!tx_payload_last) begin
              if (byte_cnt_d == MaxLen) begin
                over_d = 1'b1;
              end else begin
                rdy_d = 1'b1;
              end
            end
          end else begin
            st_d = StAbort;
          end
        end else if (byte_cnt_q < MinLen) begin
          st_d       = StPad;
          byte_cnt_d = byte_cnt_q + 11'd1;
        end else begin
          st_d  = StFcs;
          cnt_d = '0;
        end
      end
      StPad: begin
        if (byte_cnt_q == MinLen) begin
          st_d  = StFcs;
          cnt_d = '0;
        end else begin
          byte_cnt_d = byte_cnt_q + 11'd1;
        end
      end
      StFcs: begin
        if (cnt_q == 4'd3) begin
          st_d   = StGap;
          cnt_d  = '0;
          done_d = 1'b1;
          err_d  = over_q;
        end
      end
      StAbort: begin
        st_d  = StGap;
        cnt_d = '0;
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          st_d  = StIdle;
          cnt_d = '0;
        end
      end
      default: st_d = StIdle;
    endcase

    unique case (st_d)
      StPre: begin
        en_d  = 1'b1;
        txd_d = PRE;
      end
      StSfd: begin
        en_d  = 1'b1;
        txd_d = SFD;
      end
      StDst, StSrc, StType: begin
        en_d  = 1'b1;
        txd_d = hdr_q[111:104];
        hdr_d = {hdr_q[103:0], 8'h00};
      end
      StPay: begin
        en_d  = 1'b1;
        txd_d = tx_payload;
      end
      StPad: begin
        en_d = 1'b1;
      end
      StFcs: begin
        en_d  = 1'b1;
        txd_d = ~crc_q[7:0];
        crc_d = {8'h00, crc_q[31:8]};
      end
      StAbort: begin
        en_d  = 1'b1;
        er_d  = 1'b1;
        err_d = 1'b1;
      end
      default: ;
    endcase

    if (st_d inside {StDst, StSrc, StType, StPay, StPad}) begin
      crc_d = crc_step(crc_q, txd_d);
    end

    busy_d = (st_d != StIdle);
  end

  // State and registered outputs; reset drops everything to idle at once.
  always_ff @(posedge TX_CLK or posedge rst) begin
    if (rst) begin
      st_q           <= StIdle;
      cnt_q          <= '0;
      byte_cnt_q     <= '0;
      hdr_q          <= '0;
      crc_q          <= '0;
      over_q         <= 1'b0;
      tx_payload_rdy <= 1'b0;
      tx_busy        <= 1'b0;
      tx_done        <= 1'b0;
      tx_err         <= 1'b0;
      TX_EN          <= 1'b0;
      TX_ER          <= 1'b0;
      TXD            <= '0;
    end else begin
      st_q           <= st_d;
      cnt_q          <= cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      hdr_q          <= hdr_d;
      crc_q          <= crc_d;
      over_q         <= over_d;
      tx_payload_rdy <= rdy_d;
      tx_busy        <= busy_d;
      tx_done        <= done_d;
      tx_err         <= err_d;
      TX_EN          <= en_d;
      TX_ER          <= er_d;
      TXD            <= txd_d;
    end
  end

endmodule
